// File: rtl/dsp_pkg.sv
// Shared DSP types and constants: complex word, Q8 twiddles for both transform
// directions, 3-bit bit reversal and the FSM state type of the sequential IFFT.
package dsp_pkg;

  localparam int DW     = 16;
  localparam int Q_FRAC = 8;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Index t selects W^t of an 8-point transform; element [0] is t=0.
  localparam logic [3:0][DW-1:0] TW_FWD_RE = {16'hff4b, 16'h0000, 16'h00b5, 16'h0100};
  localparam logic [3:0][DW-1:0] TW_FWD_IM = {16'hff4b, 16'hff00, 16'hff4b, 16'h0000};
  localparam logic [3:0][DW-1:0] TW_INV_RE = {16'hff4b, 16'h0000, 16'h00b5, 16'h0100};
  localparam logic [3:0][DW-1:0] TW_INV_IM = {16'h00b5, 16'h0100, 16'h00b5, 16'h0000};

  typedef enum logic {ST_IDLE, ST_COMPUTE} ifft_state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/bfly_2p.sv
// Radix-2 complex butterfly: y0 = a + w*b, y1 = a - w*b, Q8 product truncated,
// wrapping DW-bit add/sub. Purely combinational.
module bfly_2p
  import dsp_pkg::*;
(
  input  cplx_t i_a,
  input  cplx_t i_b,
  input  cplx_t i_w,
  output cplx_t o_y0,
  output cplx_t o_y1
);

  logic signed [2*DW-1:0] w_br, w_bi, w_wr, w_wi;
  logic signed [2*DW-1:0] w_pr, w_pi;
  cplx_t                  w_m;

  assign w_br = {{DW{i_b.re[DW-1]}}, i_b.re};
  assign w_bi = {{DW{i_b.im[DW-1]}}, i_b.im};
  assign w_wr = {{DW{i_w.re[DW-1]}}, i_w.re};
  assign w_wi = {{DW{i_w.im[DW-1]}}, i_w.im};

  // Full-width product, then drop the Q8 fraction with an arithmetic shift.
  assign w_pr = (w_br * w_wr - w_bi * w_wi) >>> Q_FRAC;
  assign w_pi = (w_br * w_wi + w_bi * w_wr) >>> Q_FRAC;

  assign w_m.re = w_pr[DW-1:0];
  assign w_m.im = w_pi[DW-1:0];

  assign o_y0.re = i_a.re + w_m.re;
  assign o_y0.im = i_a.im + w_m.im;
  assign o_y1.re = i_a.re - w_m.re;
  assign o_y1.im = i_a.im - w_m.im;

endmodule

// File: rtl/ifft_8p_seq.sv
// 8-point radix-2 DIT inverse FFT on one time-shared butterfly (12 compute cycles).
// Define IFFT_8P_SCALE_EN to halve every butterfly output (true IDFT, 1/8 overall).
module ifft_8p_seq
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic [N-1:0][DATA_WIDTH-1:0]   X_real,
  input  logic [N-1:0][DATA_WIDTH-1:0]   X_imag,
  output logic [N-1:0][DATA_WIDTH-1:0]   x_real,
  output logic [N-1:0][DATA_WIDTH-1:0]   x_imag
);

  if (N != 8 || DATA_WIDTH != DW) begin : g_cfg_err
    $error("ifft_8p_seq supports only N=8 and DATA_WIDTH=16");
  end

  ifft_state_t                   r_state;
  logic [1:0]                    r_s;
  logic [1:0]                    r_b;
  cplx_t [N-1:0]                 r_buf;
  logic                          r_busy;
  logic                          r_done;
  logic [N-1:0][DATA_WIDTH-1:0]  r_xr;
  logic [N-1:0][DATA_WIDTH-1:0]  r_xi;

  logic [2:0] w_h, w_lo, w_top, w_bot;
  logic [1:0] w_t;
  logic       w_finish, w_accept;
  cplx_t      w_tw, w_bf0, w_bf1, w_y0, w_y1;

  // Stage s == 3 is the extra cycle that publishes the finished buffer.
  assign w_finish = (r_state == ST_COMPUTE) && (r_s == 2'd3);
  assign w_accept = start && ((r_state == ST_IDLE) || w_finish);

  always_comb begin
    w_h   = 3'd1 << r_s;
    w_lo  = {1'b0, r_b} & (w_h - 3'd1);
    w_top = ((({1'b0, r_b}) >> r_s) << (r_s + 2'd1)) | w_lo;
    w_bot = w_top + w_h;
    w_t   = 2'(w_lo << (2'd2 - r_s));
  end

  assign w_tw.re = TW_INV_RE[w_t];
  assign w_tw.im = TW_INV_IM[w_t];

  bfly_2p u_bfly (
    .i_a  (r_buf[w_top]),
    .i_b  (r_buf[w_bot]),
    .i_w  (w_tw),
    .o_y0 (w_bf0),
    .o_y1 (w_bf1)
  );

  always_comb begin
    w_y0 = w_bf0;
    w_y1 = w_bf1;
`ifdef IFFT_8P_SCALE_EN
    w_y0.re = w_bf0.re >>> 1;
    w_y0.im = w_bf0.im >>> 1;
    w_y1.re = w_bf1.re >>> 1;
    w_y1.im = w_bf1.im >>> 1;
`endif
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_b     <= '0;
      r_buf   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_xr    <= '0;
      r_xi    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: ;
        ST_COMPUTE: begin
          if (w_finish) begin
            for (int k = 0; k < N; k++) begin
              r_xr[k] <= r_buf[k].re;
              r_xi[k] <= r_buf[k].im;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_buf[w_top] <= w_y0;
            r_buf[w_bot] <= w_y1;
            r_b          <= r_b + 2'd1;
            if (r_b == 2'd3) r_s <= r_s + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A start on the publishing cycle chains the next frame without a gap.
      if (w_accept) begin
        for (int k = 0; k < N; k++)
          r_buf[k] <= '{re: X_real[bitrev3(3'(k))], im: X_imag[bitrev3(3'(k))]};
        r_s     <= '0;
        r_b     <= '0;
        r_busy  <= 1'b1;
        r_state <= ST_COMPUTE;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign x_real = r_xr;
  assign x_imag = r_xi;

endmodule
